// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: one RV32I load or store at a time against a word-wide memory
// without byte enables. Sub-word stores are done as read-modify-write.
module lsu_mem_ctrl #(
  parameter int WORD_ADDR_W = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [2:0]             req_funct3,
  input  logic [31:0]            req_addr,
  input  logic [31:0]            req_wdata,
  output logic                   rsp_valid,
  output logic                   rsp_err,
  output logic [31:0]            rsp_rdata,
  output logic [WORD_ADDR_W-1:0] mem_addr,
  output logic                   mem_re,
  input  logic [31:0]            mem_rdata,
  output logic                   mem_we,
  output logic [31:0]            mem_wdata
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_MERGE = 3'd2,
    S_WRITE = 3'd3,
    S_RESP  = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic                   we_q, we_d;
  logic [2:0]             funct3_q, funct3_d;
  logic [1:0]             addr_lo_q, addr_lo_d;
  logic [WORD_ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]            mem_wdata_q, mem_wdata_d;
  logic                   rsp_err_q, rsp_err_d;
  logic [31:0]            rsp_rdata_q, rsp_rdata_d;
  logic [7:0]             byte_s;
  logic [15:0]            half_s;
  logic [31:0]            load_s;
  logic [31:0]            merged_s;
  logic                   unused_addr_s;

  // Request legality: funct3 must name a supported access and the address must be naturally aligned.
  function automatic logic req_illegal(input logic we, input logic [2:0] f3, input logic [1:0] lo);
    logic bad;
    bad = 1'b0;
    case (f3)
      3'b000:  bad = 1'b0;
      3'b001:  bad = lo[0];
      3'b010:  bad = (lo != 2'b00);
      3'b100:  bad = we;
      3'b101:  bad = we | lo[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  assign unused_addr_s = ^req_addr[31:WORD_ADDR_W+2];

  assign req_ready = (state_q == S_IDLE);
  assign mem_re    = (state_q == S_READ);
  assign mem_we    = (state_q == S_WRITE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  // Lane extraction for loads and lane replacement for sub-word stores.
  always_comb begin
    byte_s   = mem_rdata[{addr_lo_q, 3'b000} +: 8];
    half_s   = addr_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_s   = mem_rdata;
    merged_s = mem_rdata;
    case (funct3_q)
      3'b000:  load_s = {{24{byte_s[7]}}, byte_s};
      3'b100:  load_s = {24'd0, byte_s};
      3'b001:  load_s = {{16{half_s[15]}}, half_s};
      3'b101:  load_s = {16'd0, half_s};
      default: load_s = mem_rdata;
    endcase
    if (funct3_q == 3'b000) begin
      merged_s[{addr_lo_q, 3'b000} +: 8] = mem_wdata_q[7:0];
    end else begin
      merged_s[{addr_lo_q[1], 4'b0000} +: 16] = mem_wdata_q[15:0];
    end
  end

  // Next-state and next-register logic of the access sequencer.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    funct3_d    = funct3_q;
    addr_lo_d   = addr_lo_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d        = req_we;
          funct3_d    = req_funct3;
          addr_lo_d   = req_addr[1:0];
          mem_addr_d  = req_addr[WORD_ADDR_W+1:2];
          mem_wdata_d = req_wdata;
          if (req_illegal(req_we, req_funct3, req_addr[1:0])) begin
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'd0;
            state_d     = S_RESP;
          end else if (req_we && (req_funct3 == 3'b010)) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_READ;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ:  state_d = S_MERGE;
      S_MERGE: begin
        if (we_q) begin
          mem_wdata_d = merged_s;
          state_d     = S_WRITE;
        end else begin
          rsp_err_d   = 1'b0;
          rsp_rdata_d = load_s;
          state_d     = S_RESP;
        end
      end
      S_WRITE: begin
        rsp_err_d   = 1'b0;
        rsp_rdata_d = 32'd0;
        state_d     = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and captured-request registers; reset abandons any access in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      funct3_q    <= 3'd0;
      addr_lo_q   <= 2'd0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      addr_lo_q   <= addr_lo_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: directed vectors, randomized traffic
// against a byte-lane reference model, held-valid backpressure and reset abort.
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic [9:0]  mem_addr;
  logic        mem_re;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_we;
  logic [31:0] mem_wdata;

  logic [31:0] mem     [1024];
  logic [31:0] ref_mem [1024];
  int total = 0;
  int bad   = 0;

  lsu_mem_ctrl #(.WORD_ADDR_W(10)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_rdata(mem_rdata),
    .mem_we(mem_we), .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;

  // Word memory: registered read, full-word write.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  // ---------------- reference model (byte-lane arithmetic) ----------------
  function automatic int m_size(input logic [2:0] f3);
    return int'(f3 % 3'd4);  // 0 byte, 1 half, 2 word
  endfunction

  function automatic bit m_illegal(input bit we, input logic [2:0] f3, input logic [31:0] a);
    int nbytes;
    if (we && f3 > 3'd2) return 1'b1;
    if (!we && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 1'b1;
    nbytes = 1 << m_size(f3);
    return (a % nbytes) != 0;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] w, input logic [2:0] f3, input logic [31:0] a);
    int v;
    if (m_size(f3) == 2) return w;
    if (m_size(f3) == 0) begin
      v = int'((w >> (8 * (a % 4))) % 256);
      if (f3 < 3'd4 && v >= 128) v = v - 256;
    end else begin
      v = int'((w >> (16 * ((a / 2) % 2))) % 65536);
      if (f3 < 3'd4 && v >= 32768) v = v - 65536;
    end
    return v;
  endfunction

  function automatic logic [31:0] m_store(input logic [31:0] w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] mask;
    int sh;
    if (m_size(f3) == 2) return d;
    mask = (m_size(f3) == 0) ? 32'h0000_00FF : 32'h0000_FFFF;
    sh   = (m_size(f3) == 0) ? 8 * int'(a % 4) : 16 * int'((a / 2) % 2);
    return (w & ~(mask << sh)) | ((d & mask) << sh);
  endfunction

  function automatic int m_latency(input bit we, input logic [2:0] f3, input logic [31:0] a);
    if (m_illegal(we, f3, a)) return 1;
    if (we && f3 == 3'd2) return 2;
    if (!we) return 3;
    return 4;
  endfunction

  // Issue one request and observe it until its response (bounded).
  task automatic do_req(input bit we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output logic er,
                        output int nre, output int nwe, output int both);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; rd = 32'hx; er = 1'bx; nre = 0; nwe = 0; both = 0;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      @(negedge clk);
      if (mem_re) nre++;
      if (mem_we) nwe++;
      if (mem_re && mem_we) both++;
      if (rsp_valid) begin lat = c; rd = rsp_rdata; er = rsp_err; end
    end
  endtask

  task automatic test_reset;
    total++;
    if ({req_ready, rsp_valid, rsp_err, mem_re, mem_we} !== 5'b10000) begin
      bad++; $display("FAIL reset_ctrl got=%b want=10000", {req_ready, rsp_valid, rsp_err, mem_re, mem_we});
    end
    total++;
    if (rsp_rdata !== 32'd0 || mem_addr !== 10'd0 || mem_wdata !== 32'd0) begin
      bad++; $display("FAIL reset_data rdata=%h addr=%h wdata=%h want all 0", rsp_rdata, mem_addr, mem_wdata);
    end
  endtask

  typedef struct { bit we; logic [2:0] f3; logic [31:0] a; logic [31:0] wd; logic [31:0] exp_rd; } vec_t;

  task automatic test_directed;
    vec_t v [13];
    int lat, nre, nwe, both, elat;
    logic [31:0] rd;
    logic er, eerr;
    mem[64] = 32'd0; ref_mem[64] = 32'd0;
    v[0]  = '{1, 3'd0, 32'h100, 32'h1234_56AA, 32'h0};
    v[1]  = '{1, 3'd0, 32'h101, 32'h9876_54BB, 32'h0};
    v[2]  = '{1, 3'd1, 32'h102, 32'h1111_DDEE, 32'h0};
    v[3]  = '{1, 3'd2, 32'h104, 32'hDEAD_BEEF, 32'h0};
    v[4]  = '{0, 3'd0, 32'h103, 32'h0, 32'hFFFF_FFDD};
    v[5]  = '{0, 3'd4, 32'h103, 32'h0, 32'h0000_00DD};
    v[6]  = '{0, 3'd1, 32'h102, 32'h0, 32'hFFFF_DDEE};
    v[7]  = '{0, 3'd5, 32'h100, 32'h0, 32'h0000_BBAA};
    v[8]  = '{0, 3'd2, 32'h100, 32'h0, 32'hDDEE_BBAA};
    v[9]  = '{1, 3'd2, 32'h102, 32'h5555_5555, 32'h0};
    v[10] = '{0, 3'd1, 32'h101, 32'h0, 32'h0};
    v[11] = '{0, 3'd3, 32'h100, 32'h0, 32'h0};
    v[12] = '{1, 3'd1, 32'h105, 32'h7777_7777, 32'h0};
    foreach (v[i]) begin
      do_req(v[i].we, v[i].f3, v[i].a, v[i].wd, lat, rd, er, nre, nwe, both);
      elat = (i >= 9) ? 1 : ((v[i].we && v[i].f3 == 3'd2) ? 2 : (v[i].we ? 4 : 3));
      eerr = (i >= 9);
      total++;
      if (lat !== elat || er !== eerr || rd !== v[i].exp_rd) begin
        bad++; $display("FAIL dir_rsp[%0d] lat=%0d err=%b rd=%h want lat=%0d err=%b rd=%h", i, lat, er, rd, elat, eerr, v[i].exp_rd);
      end
      total++;
      if (nre != ((elat >= 3) ? 1 : 0) || nwe != ((elat == 2 || elat == 4) ? 1 : 0) || both != 0) begin
        bad++; $display("FAIL dir_strobes[%0d] re=%0d we=%0d both=%0d for lat=%0d", i, nre, nwe, both, elat);
      end
      if (i == 2) begin
        total++;
        if (mem[64] !== 32'hDDEE_BBAA) begin bad++; $display("FAIL dir_sbsh_word got=%h want=ddeebbaa", mem[64]); end
      end
    end
    total++;
    if (mem[64] !== 32'hDDEE_BBAA || mem[65] !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL dir_mem_after_err m64=%h m65=%h want ddeebbaa deadbeef", mem[64], mem[65]);
    end
    ref_mem[64] = 32'hDDEE_BBAA; ref_mem[65] = 32'hDEAD_BEEF;
  endtask

  task automatic test_random;
    int lat, nre, nwe, both, idx, elat;
    logic [31:0] rd, a, wd, erd;
    logic er;
    bit we, eerr;
    logic [2:0] f3;
    for (int n = 0; n < 120; n++) begin
      we  = 1'($urandom % 2);
      f3  = 3'($urandom % 8);
      a   = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(32'h100, 32'h11F));
      wd  = $urandom;
      idx = int'((a >> 2) % 1024);
      eerr = m_illegal(we, f3, a);
      elat = m_latency(we, f3, a);
      erd  = (eerr || we) ? 32'd0 : m_load(ref_mem[idx], f3, a);
      if (!eerr && we) ref_mem[idx] = m_store(ref_mem[idx], f3, a, wd);
      do_req(we, f3, a, wd, lat, rd, er, nre, nwe, both);
      total++;
      if (lat !== elat || er !== eerr || rd !== erd || both != 0) begin
        bad++; $display("FAIL rnd_rsp[%0d] we=%0d f3=%0d a=%h lat=%0d err=%b rd=%h both=%0d want lat=%0d err=%b rd=%h",
                        n, we, f3, a, lat, er, rd, both, elat, eerr, erd);
      end
      total++;
      if (mem[idx] !== ref_mem[idx]) begin
        bad++; $display("FAIL rnd_mem[%0d] word=%0d got=%h want=%h", n, idx, mem[idx], ref_mem[idx]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int resp_c, ready_c, nre, lat;
    logic [31:0] wd, rd;
    wd = $urandom;
    ref_mem[67] = m_store(ref_mem[67], 3'd0, 32'h10D, wd);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h10D; req_wdata = wd;
    @(posedge clk);
    #1 req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h10C; req_wdata = ~wd;
    resp_c = 0; ready_c = 0; nre = 0;
    for (int c = 1; c <= 12 && ready_c == 0; c++) begin
      @(negedge clk);
      if (mem_re) nre++;
      if (rsp_valid) resp_c = c;
      if (req_ready) ready_c = c;
    end
    total++;
    if (resp_c != 4 || ready_c != 5 || nre != 1) begin
      bad++; $display("FAIL b2b_busy resp=%0d ready=%0d re=%0d want 4 5 1", resp_c, ready_c, nre);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; rd = 32'hx;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      @(negedge clk);
      if (rsp_valid) begin lat = c; rd = rsp_rdata; end
    end
    total++;
    if (lat != 3 || rd !== ref_mem[67]) begin
      bad++; $display("FAIL b2b_second lat=%0d rd=%h want 3 %h", lat, rd, ref_mem[67]);
    end
  endtask

  task automatic test_reset_abort;
    int seen, rsp_seen, lat, nre, nwe, both;
    logic [31:0] rd;
    logic er;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd1; req_addr = 32'h10A; req_wdata = ~ref_mem[66];
    @(posedge clk);
    #1 req_valid = 1'b0;
    seen = 0;
    for (int c = 1; c <= 10 && seen == 0; c++) begin
      @(negedge clk);
      if (mem_we) seen = c;
    end
    total++;
    if (seen != 3) begin bad++; $display("FAIL abort_write_cycle got=%0d want=3", seen); end
    rst = 1'b0;
    #1;
    total++;
    if (mem_we !== 1'b0 || req_ready !== 1'b1) begin
      bad++; $display("FAIL abort_async we=%b ready=%b want 0 1", mem_we, req_ready);
    end
    rsp_seen = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (rsp_valid) rsp_seen++;
    end
    rst = 1'b1;
    total++;
    if (rsp_seen != 0 || mem[66] !== ref_mem[66]) begin
      bad++; $display("FAIL abort_effect rsp=%0d mem=%h want 0 %h", rsp_seen, mem[66], ref_mem[66]);
    end
    do_req(1'b0, 3'd2, 32'h108, 32'd0, lat, rd, er, nre, nwe, both);
    total++;
    if (lat != 3 || rd !== ref_mem[66] || er !== 1'b0) begin
      bad++; $display("FAIL abort_reload lat=%0d rd=%h err=%b want 3 %h 0", lat, rd, er, ref_mem[66]);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    repeat (3) @(negedge clk);
    test_reset;
    rst = 1'b1;
    @(negedge clk);
    test_directed;
    test_random;
    test_back_to_back;
    test_reset_abort;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
